// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full_adder plus a carry flop, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]       state;
  logic [WIDTH-1:0] sa, sb, acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             c, fs, fc, load, last;
  full_adder u_fa (.a(sa[0]), .b(sb[0]), .ci(c), .s(fs), .co(fc));
  always_comb begin
    load   = start && state != RUN;
    last   = state == RUN && cnt == LAST;
    acc_nx = (acc >> 1) | {fs, {(WIDTH-1){1'b0}}};
    busy   = state == RUN;
    done   = state == DONE;
  end
  // DONE also accepts start so back-to-back operations lose no extra cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      if (load) begin
        sa    <= a;
        sb    <= b;
        c     <= cin;
        cnt   <= '0;
        acc   <= '0;
        state <= RUN;
      end else if (state == RUN) begin
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        acc   <= acc_nx;
        c     <= fc;
        cnt   <= cnt + 1'b1;
        state <= last ? DONE : RUN;
      end else begin
        state <= IDLE;
      end
      if (last) begin
        sum  <= acc_nx;
        cout <= fc;
      end
    end
  end
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the 8-bit adder plus an exhaustive 3-bit sweep
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n, start, cin, busy, done, cout;
  logic [7:0] a, b, sum;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;
  int nvec = 0;
  int nerr = 0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  serial_adder #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  always #5 clk = ~clk;

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      output int nb, output int nd);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
    nb = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    nvec++; if (sum !== 8'h00) begin nerr++; $display("FAIL reset_sum got %h want 00", sum); end
    nvec++; if (cout !== 1'b0) begin nerr++; $display("FAIL reset_cout got %b want 0", cout); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] va[4] = '{8'h00, 8'hFF, 8'hA5, 8'h12};
    logic [7:0] vb[4] = '{8'h00, 8'h01, 8'h5A, 8'h34};
    logic       vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] ex[4] = '{9'h000, 9'h100, 9'h100, 9'h046};
    int nb, nd;
    for (int k = 0; k < 4; k++) begin
      run8(va[k], vb[k], vc[k], nb, nd);
      nvec++; if (nb != 8) begin nerr++; $display("FAIL basic%0d_busy_cycles got %0d want 8", k, nb); end
      nvec++; if (nd != 1) begin nerr++; $display("FAIL basic%0d_done_pulses got %0d want 1", k, nd); end
      nvec++; if ({cout, sum} !== ex[k]) begin nerr++; $display("FAIL basic%0d_result got %h want %h", k, {cout, sum}, ex[k]); end
    end
  endtask

  task automatic test_ignore_start;
    int nb = 0, nd = 0;
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy) nb++;
      if (done) nd++;
      if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    nvec++; if (nb != 8) begin nerr++; $display("FAIL ignore_busy_cycles got %0d want 8", nb); end
    nvec++; if (nd != 1) begin nerr++; $display("FAIL ignore_done_pulses got %0d want 1", nd); end
    nvec++; if ({cout, sum} !== 9'h010) begin nerr++; $display("FAIL ignore_result got %h want 010", {cout, sum}); end
  endtask

  task automatic test_reset_mid;
    int nb, nd = 0;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL midrst_done got %b want 0", done); end
    nvec++; if (sum !== 8'h00) begin nerr++; $display("FAIL midrst_sum got %h want 00", sum); end
    nvec++; if (cout !== 1'b0) begin nerr++; $display("FAIL midrst_cout got %b want 0", cout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    nvec++; if (nd != 0) begin nerr++; $display("FAIL midrst_stray_done got %0d want 0", nd); end
    run8(8'h03, 8'h04, 1'b0, nb, nd);
    nvec++; if (nd != 1) begin nerr++; $display("FAIL midrst_next_done got %0d want 1", nd); end
    nvec++; if ({cout, sum} !== 9'h007) begin nerr++; $display("FAIL midrst_next_result got %h want 007", {cout, sum}); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] oa[4] = '{8'h01, 8'hFF, 8'h80, 8'h55};
    logic [7:0] ob[4] = '{8'h02, 8'hFF, 8'h80, 8'h22};
    logic       oc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [8:0] ex[4] = '{9'h003, 9'h1FF, 9'h100, 9'h078};
    int k = 0, lastt = 0;
    @(negedge clk);
    a = oa[0]; b = ob[0]; cin = oc[0]; start = 1'b1;
    for (int t = 0; t < 60 && k < 4; t++) begin
      @(negedge clk);
      if (done) begin
        nvec++; if ({cout, sum} !== ex[k]) begin nerr++; $display("FAIL b2b%0d_result got %h want %h", k, {cout, sum}, ex[k]); end
        if (k > 0) begin
          nvec++; if (t - lastt != 9) begin nerr++; $display("FAIL b2b%0d_spacing got %0d want 9", k, t - lastt); end
        end
        lastt = t;
        k++;
        if (k < 4) begin a = oa[k]; b = ob[k]; cin = oc[k]; end
        else start = 1'b0;
      end else begin
        a = 8'(t * 37 + 5); b = 8'(t * 91 + 13); cin = t[0];
      end
    end
    start = 1'b0;
    nvec++; if (k != 4) begin nerr++; $display("FAIL b2b_timeout got %0d results want 4", k); end
  endtask

  task automatic test_width3;
    logic [3:0] ex;
    bit seen;
    @(negedge clk);
    for (int v = 0; v < 128; v++) begin
      a3 = v[6:4]; b3 = v[3:1]; cin3 = v[0]; start3 = 1'b1;
      ex = 4'(a3) + 4'(b3) + 4'(cin3);
      @(negedge clk);
      start3 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
        @(negedge clk);
        seen = done3;
      end
      nvec++;
      if (!seen || {cout3, sum3} !== ex) begin
        nerr++;
        $display("FAIL w3_a%0d_b%0d_c%0d got %h done=%b want %h", v[6:4], v[3:1], v[0], {cout3, sum3}, seen, ex);
      end
    end
  endtask

  initial begin
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    test_reset;
    test_basic;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_width3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
